fsm_empacotador: RTL and testbench
==================================

// Module: fsm_empacotador
// PURPOSE
//   Downstream packing stage of the bottling line. Consumes approved bottles that reach the end of the conveyor and places them in a case.
//   Seals each full case of GARRAFAS_POR_CAIXA bottles, pulses the dozen counter, and runs the case-swap handshake with the operator.
//   Drops pronto_receber as back-pressure so the master sequencer holds the motor while the arm or sealer is busy.
// PARAMETERS
//   GARRAFAS_POR_CAIXA  12   bottles per case (>=2)
//   TEMPO_DEPOSITO      25   cycles the pick arm needs per bottle (>=1)
//   TEMPO_SELAGEM       50   cycles the case sealer needs (>=1)
//   TIMEOUT_TROCA       1000 cycles allowed in TROCA before alarm (only with the macro)
//   MAX_CAIXAS          99   saturation value of total_caixas (2-digit display)
// PORTS
//   clk               in   1  system clock, 50 MHz
//   reset             in   1  synchronous, active-low; reset==0 at a rising edge resets the block
//   garrafa_valida    in   1  1-cycle pulse: approved bottle at the exit position
//   sensor_caixa      in   1  level: case present under the arm
//   pronto_receber    out  1  high only in RECEBE; master must not move a bottle to the exit while low
//   braco_ativo       out  1  pick-arm actuator (LED)
//   selagem_ativa     out  1  sealer actuator (LED)
//   pedido_troca      out  1  operator request: remove the full case
//   caixa_cheia       out  1  1-cycle pulse per sealed case; drives incrementar_duzia
//   garrafas_na_caixa out  $clog2(GARRAFAS_POR_CAIXA+1)  bottles in the current case
//   total_caixas      out  7  sealed cases, saturating at MAX_CAIXAS
//   erro_sequencia    out  1  sticky; cleared only by reset
//   alarme_troca      out  1  sticky swap timeout; cleared only by reset
// BEHAVIOUR
//   Moore FSM. Every output is registered or decoded from the registered state. No combinational path from input to output.
//   Reset: state=ESPERA_CAIXA. All outputs 0, all counters 0.
//   ESPERA_CAIXA: waits for sensor_caixa==1, then goes to RECEBE on the next edge.
//   RECEBE: pronto_receber=1.
//     - garrafa_valida -> DEPOSITA on the next edge.
//     - sensor_caixa==0 -> ESPERA_CAIXA. garrafas_na_caixa clears to 0 and erro_sequencia sets.
//     - If both happen in the same cycle, case removal wins and the bottle is lost.
//   DEPOSITA: braco_ativo=1 for exactly TEMPO_DEPOSITO cycles.
//     - On exit, garrafas_na_caixa increments by 1.
//     - If the new count equals GARRAFAS_POR_CAIXA, go to SELA; otherwise go to RECEBE.
//     - A bottle pulse at edge N gives braco_ativo high on cycles N+1 .. N+TEMPO_DEPOSITO.
//   SELA: selagem_ativa=1 for exactly TEMPO_SELAGEM cycles.
//     - On exit: caixa_cheia is high for 1 cycle, total_caixas increments (held at MAX_CAIXAS), garrafas_na_caixa clears to 0.
//     - Then go to TROCA.
//   TROCA: pedido_troca=1 until sensor_caixa==0, then go to ESPERA_CAIXA.
//   garrafa_valida outside RECEBE: the bottle is ignored, erro_sequencia sets, and the state is unchanged.
//   Case removed during DEPOSITA/SELA: ignored. The operation completes and the later states handle it.
//   Internal cycle counter: one shared counter, cleared on every state entry, wide enough for max(TEMPO_*, TIMEOUT_TROCA).
//   Reset mid-operation: returns to the reset state immediately. The partial case count is discarded.
// CONFIGURATION
//   EMPACOTADOR_TIMEOUT_TROCA_EN
//   Defined: the cycle counter runs in TROCA.
//     - After TIMEOUT_TROCA cycles with sensor_caixa still 1, alarme_troca sets (sticky).
//     - The FSM stays in TROCA until the case is removed.
//   Undefined: no timeout logic; alarme_troca is tied to 0.
// TESTING (GARRAFAS_POR_CAIXA=3, TEMPO_DEPOSITO=2, TEMPO_SELAGEM=4, TIMEOUT_TROCA=8)
//   1. Hold reset=0 for 2 cycles, sensor_caixa=0 -> all outputs 0; 1 cycle after sensor_caixa=1, pronto_receber=1.
//   2. Case present, 1 bottle pulse -> braco_ativo high 2 cycles, pronto_receber low 2 cycles, garrafas_na_caixa=1.
//   3. Case present, 3 bottles -> selagem_ativa high 4 cycles; caixa_cheia single pulse; total_caixas=1, count=0; pedido_troca=1 until sensor_caixa=0.
//   4. Bottle pulse during DEPOSITA -> count unchanged, erro_sequencia=1; case removed in RECEBE with count=2 -> count=0, ESPERA_CAIXA.
//   5. Run 100 full cases -> total_caixas saturates at 99; caixa_cheia still pulses on every case.
//   6. Macro on: hold sensor_caixa=1 in TROCA for 9 cycles -> alarme_troca=1, pedido_troca stays 1. Macro off: alarme_troca stays 0.

Source files
------------

// File: rtl/fsm_empacotador_if.sv
`timescale 1ns/1ps
// fsm_empacotador_if
//   Bundles the packing-stage signals exchanged between the line sequencer
//   (master) and the packing FSM (slave). Clock and reset stay outside.
//
//   garrafa_valida    master->slave  1-cycle pulse: approved bottle at exit
//   sensor_caixa      master->slave  level: case present under the arm
//   pronto_receber    slave->master  back-pressure, high only while receiving
//   braco_ativo       slave->master  pick-arm actuator
//   selagem_ativa     slave->master  sealer actuator
//   pedido_troca      slave->master  operator request to remove the full case
//   caixa_cheia       slave->master  1-cycle pulse per sealed case
//   garrafas_na_caixa slave->master  bottles in the current case
//   total_caixas      slave->master  sealed cases, saturating
//   erro_sequencia    slave->master  sticky sequence error
//   alarme_troca      slave->master  sticky swap timeout
interface fsm_empacotador_if #(
    parameter int GARRAFAS_POR_CAIXA = 12
);
    localparam int CW = $clog2(GARRAFAS_POR_CAIXA + 1);

    logic          garrafa_valida;
    logic          sensor_caixa;
    logic          pronto_receber;
    logic          braco_ativo;
    logic          selagem_ativa;
    logic          pedido_troca;
    logic          caixa_cheia;
    logic [CW-1:0] garrafas_na_caixa;
    logic [6:0]    total_caixas;
    logic          erro_sequencia;
    logic          alarme_troca;

    modport master (
        output garrafa_valida,
        output sensor_caixa,
        input  pronto_receber,
        input  braco_ativo,
        input  selagem_ativa,
        input  pedido_troca,
        input  caixa_cheia,
        input  garrafas_na_caixa,
        input  total_caixas,
        input  erro_sequencia,
        input  alarme_troca
    );

    modport slave (
        input  garrafa_valida,
        input  sensor_caixa,
        output pronto_receber,
        output braco_ativo,
        output selagem_ativa,
        output pedido_troca,
        output caixa_cheia,
        output garrafas_na_caixa,
        output total_caixas,
        output erro_sequencia,
        output alarme_troca
    );
endinterface

// File: rtl/fsm_empacotador.sv
`timescale 1ns/1ps
// fsm_empacotador
//   Packing stage at the end of the bottling conveyor. Places each approved
//   bottle in the case under the arm, seals the case once it holds
//   GARRAFAS_POR_CAIXA bottles, pulses caixa_cheia per sealed case and asks
//   the operator to swap the case. pronto_receber is low whenever the arm or
//   the sealer is busy so the sequencer holds the conveyor motor.
//
//   Ports:
//     clk    system clock (50 MHz)
//     reset  synchronous, active-low
//     bus    fsm_empacotador_if.slave (see the interface file for signals)
//
//   Optional feature: define EMPACOTADOR_TIMEOUT_TROCA_EN to raise the sticky
//   alarme_troca when the full case is not removed within TIMEOUT_TROCA
//   cycles. Without it alarme_troca is tied low.
//
//   Moore machine: every output is a flop or a decode of the state flop, so
//   there is no combinational path from an input to an output.
module fsm_empacotador #(
    parameter int GARRAFAS_POR_CAIXA = 12,
    parameter int TEMPO_DEPOSITO     = 25,
    parameter int TEMPO_SELAGEM      = 50,
    parameter int TIMEOUT_TROCA      = 1000,
    parameter int MAX_CAIXAS         = 99
) (
    input  logic              clk,
    input  logic              reset,
    fsm_empacotador_if.slave  bus
);
    localparam int CW       = $clog2(GARRAFAS_POR_CAIXA + 1);
    localparam int T_MAX_DS = (TEMPO_DEPOSITO > TEMPO_SELAGEM) ? TEMPO_DEPOSITO : TEMPO_SELAGEM;
    localparam int T_MAX    = (T_MAX_DS > TIMEOUT_TROCA) ? T_MAX_DS : TIMEOUT_TROCA;
    localparam int TW       = $clog2(T_MAX + 1);

    // Last counter value of each timed phase: the phase lasts exactly N cycles.
    localparam logic [TW-1:0] FIM_DEPOSITO = TW'(TEMPO_DEPOSITO - 1);
    localparam logic [TW-1:0] FIM_SELAGEM  = TW'(TEMPO_SELAGEM - 1);
`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
    localparam logic [TW-1:0] FIM_TIMEOUT  = TW'(TIMEOUT_TROCA - 1);
`endif
    localparam logic [CW-1:0] CAIXA_CHEIA  = CW'(GARRAFAS_POR_CAIXA);
    localparam logic [6:0]    TOTAL_MAX    = 7'(MAX_CAIXAS);

    typedef enum logic [2:0] {
        ESPERA_CAIXA = 3'd0,
        RECEBE       = 3'd1,
        DEPOSITA     = 3'd2,
        SELA         = 3'd3,
        TROCA        = 3'd4
    } estado_t;

    estado_t         estado_q,      estado_d;
    logic [TW-1:0]   ciclos_q,      ciclos_d;
    logic [CW-1:0]   garrafas_q,    garrafas_d;
    logic [6:0]      total_q,       total_d;
    logic            caixa_cheia_q, caixa_cheia_d;
    logic            erro_q,        erro_d;
`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
    logic            alarme_q,      alarme_d;
`endif
    logic [CW-1:0]   proxima_contagem;
    logic            garrafa_fora;

    // Case counter that holds at the display limit instead of wrapping.
    function automatic logic [6:0] incrementa_saturado(input logic [6:0] valor);
        logic [6:0] resultado;
        if (valor >= TOTAL_MAX) begin
            resultado = TOTAL_MAX;
        end else begin
            resultado = valor + 7'd1;
        end
        return resultado;
    endfunction

    // Next-state, counter and status computation.
    always_comb begin
        estado_d         = estado_q;
        // The shared cycle counter defaults to zero; only phases that stay
        // put advance it, so every state entry starts the count at zero.
        ciclos_d         = {TW{1'b0}};
        garrafas_d       = garrafas_q;
        total_d          = total_q;
        caixa_cheia_d    = 1'b0;
        proxima_contagem = garrafas_q + CW'(1);
        // A bottle arriving while not receiving is dropped but flagged.
        garrafa_fora     = bus.garrafa_valida && (estado_q != RECEBE);
        erro_d           = erro_q | garrafa_fora;
`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
        alarme_d         = alarme_q;
`endif

        case (estado_q)
            ESPERA_CAIXA: begin
                if (bus.sensor_caixa) begin
                    estado_d = RECEBE;
                end else begin
                    estado_d = ESPERA_CAIXA;
                end
            end

            RECEBE: begin
                // Case removal takes priority; a simultaneous bottle is lost.
                if (!bus.sensor_caixa) begin
                    estado_d   = ESPERA_CAIXA;
                    garrafas_d = {CW{1'b0}};
                    erro_d     = 1'b1;
                end else if (bus.garrafa_valida) begin
                    estado_d = DEPOSITA;
                end else begin
                    estado_d = RECEBE;
                end
            end

            DEPOSITA: begin
                // Case removal here is ignored; the arm finishes its move.
                if (ciclos_q == FIM_DEPOSITO) begin
                    garrafas_d = proxima_contagem;
                    if (proxima_contagem == CAIXA_CHEIA) begin
                        estado_d = SELA;
                    end else begin
                        estado_d = RECEBE;
                    end
                end else begin
                    ciclos_d = ciclos_q + TW'(1);
                end
            end

            SELA: begin
                if (ciclos_q == FIM_SELAGEM) begin
                    estado_d      = TROCA;
                    caixa_cheia_d = 1'b1;
                    total_d       = incrementa_saturado(total_q);
                    garrafas_d    = {CW{1'b0}};
                end else begin
                    ciclos_d = ciclos_q + TW'(1);
                end
            end

            TROCA: begin
                if (!bus.sensor_caixa) begin
                    estado_d = ESPERA_CAIXA;
                end else begin
`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
                    // Counter parks at the limit so the alarm keeps being set.
                    if (ciclos_q == FIM_TIMEOUT) begin
                        alarme_d = 1'b1;
                        ciclos_d = ciclos_q;
                    end else begin
                        ciclos_d = ciclos_q + TW'(1);
                    end
`else
                    estado_d = TROCA;
`endif
                end
            end

            default: begin
                estado_d   = ESPERA_CAIXA;
                garrafas_d = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q      <= ESPERA_CAIXA;
            ciclos_q      <= {TW{1'b0}};
            garrafas_q    <= {CW{1'b0}};
            total_q       <= 7'd0;
            caixa_cheia_q <= 1'b0;
            erro_q        <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            ciclos_q      <= ciclos_d;
            garrafas_q    <= garrafas_d;
            total_q       <= total_d;
            caixa_cheia_q <= caixa_cheia_d;
            erro_q        <= erro_d;
        end
    end

`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
    // Sticky swap-timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alarme_q <= 1'b0;
        end else begin
            alarme_q <= alarme_d;
        end
    end

    assign bus.alarme_troca = alarme_q;
`else
    assign bus.alarme_troca = 1'b0;
`endif

    // Actuators and handshake are pure decodes of the state register.
    assign bus.pronto_receber    = (estado_q == RECEBE);
    assign bus.braco_ativo       = (estado_q == DEPOSITA);
    assign bus.selagem_ativa     = (estado_q == SELA);
    assign bus.pedido_troca      = (estado_q == TROCA);
    assign bus.caixa_cheia       = caixa_cheia_q;
    assign bus.garrafas_na_caixa = garrafas_q;
    assign bus.total_caixas      = total_q;
    assign bus.erro_sequencia    = erro_q;
endmodule

// File: tb/tb_fsm_empacotador.sv
`timescale 1ns/1ps
// Self-checking bench for fsm_empacotador with a small configuration.
// The driver issues bottles and case swaps; the reference model turns each
// bottle into expected events (deposit finished, case sealed) in a queue, and
// an independent monitor pops and compares them whenever the DUT shows the
// matching output activity.
module tb_fsm_empacotador;
    localparam int G    = 3;
    localparam int TD   = 2;
    localparam int TS   = 4;
    localparam int TO   = 8;
    localparam int MAXC = 99;
    localparam int EV_DEP  = 0;
    localparam int EV_SEAL = 1;
`ifdef EMPACOTADOR_TIMEOUT_TROCA_EN
    localparam int EXP_ALARME = 1;
`else
    localparam int EXP_ALARME = 0;
`endif

    typedef struct {
        int kind;
        int cnt;
        int total;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_count = 0;
    int   m_total = 0;

    always #10 clk = ~clk;

    fsm_empacotador_if #(.GARRAFAS_POR_CAIXA(G)) bus ();

    fsm_empacotador #(
        .GARRAFAS_POR_CAIXA (G),
        .TEMPO_DEPOSITO     (TD),
        .TEMPO_SELAGEM      (TS),
        .TIMEOUT_TROCA      (TO),
        .MAX_CAIXAS         (MAXC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string nome, input int atual, input int esperado);
        n_tests++;
        if (atual != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pronto"},   int'(bus.pronto_receber), 0);
        check({tag, "_braco"},    int'(bus.braco_ativo), 0);
        check({tag, "_selagem"},  int'(bus.selagem_ativa), 0);
        check({tag, "_pedido"},   int'(bus.pedido_troca), 0);
        check({tag, "_cheia"},    int'(bus.caixa_cheia), 0);
        check({tag, "_garrafas"}, int'(bus.garrafas_na_caixa), 0);
        check({tag, "_total"},    int'(bus.total_caixas), 0);
        check({tag, "_erro"},     int'(bus.erro_sequencia), 0);
        check({tag, "_alarme"},   int'(bus.alarme_troca), 0);
    endtask

    task automatic wait_pronto();
        int k = 0;
        while (bus.pronto_receber !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (bus.pronto_receber !== 1'b1) check("timeout_pronto", 0, 1);
    endtask

    task automatic wait_pedido();
        int k = 0;
        while (bus.pedido_troca !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (bus.pedido_troca !== 1'b1) check("timeout_pedido", 0, 1);
    endtask

    // One legal bottle; the model derives the events it must cause.
    task automatic garrafa();
        wait_pronto();
        bus.garrafa_valida = 1'b1;
        m_count++;
        sb_q.push_back('{kind: EV_DEP, cnt: m_count, total: 0});
        if (m_count == G) begin
            m_total = (m_total < MAXC) ? m_total + 1 : MAXC;
            m_count = 0;
            sb_q.push_back('{kind: EV_SEAL, cnt: 0, total: m_total});
        end
        @(negedge clk);
        bus.garrafa_valida = 1'b0;
    endtask

    // Operator removes the sealed case after a short delay and puts a new one.
    task automatic troca(input int espera);
        wait_pedido();
        repeat (espera) @(negedge clk);
        bus.sensor_caixa = 1'b0;
        @(negedge clk);
        check("pedido_apos_retirada", int'(bus.pedido_troca), 0);
        bus.sensor_caixa = 1'b1;
    endtask

    // Monitor: pops expected events when the DUT finishes a deposit or seal.
    initial begin : monitor
        int   braco_run;
        int   sel_run;
        logic prev_braco;
        logic prev_cc;
        exp_t e;
        braco_run  = 0;
        sel_run    = 0;
        prev_braco = 1'b0;
        prev_cc    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                braco_run  = 0;
                sel_run    = 0;
                prev_braco = 1'b0;
                prev_cc    = 1'b0;
            end else begin
                if (bus.braco_ativo === 1'b1) begin
                    braco_run++;
                end else if (prev_braco) begin
                    if (sb_q.size() == 0) begin
                        check("deposito_inesperado", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("evento_deposito", EV_DEP, e.kind);
                        check("duracao_braco", braco_run, TD);
                        check("garrafas_apos_deposito", int'(bus.garrafas_na_caixa), e.cnt);
                        check("pronto_apos_deposito", int'(bus.pronto_receber), (e.cnt != G) ? 1 : 0);
                        check("selagem_apos_deposito", int'(bus.selagem_ativa), (e.cnt == G) ? 1 : 0);
                    end
                    braco_run = 0;
                end
                if (bus.selagem_ativa === 1'b1) sel_run++;
                if (bus.caixa_cheia === 1'b1) begin
                    check("cheia_um_ciclo", int'(prev_cc), 0);
                    if (sb_q.size() == 0) begin
                        check("selagem_inesperada", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("evento_selagem", EV_SEAL, e.kind);
                        check("duracao_selagem", sel_run, TS);
                        check("total_caixas", int'(bus.total_caixas), e.total);
                        check("garrafas_apos_selagem", int'(bus.garrafas_na_caixa), 0);
                        check("pedido_apos_selagem", int'(bus.pedido_troca), 1);
                    end
                    sel_run = 0;
                end
                prev_braco = bus.braco_ativo;
                prev_cc    = bus.caixa_cheia;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus.garrafa_valida = 1'b0;
        bus.sensor_caixa   = 1'b0;
        reset              = 1'b0;

        // Reset held two cycles with no case: everything quiet.
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        check("espera_sem_caixa", int'(bus.pronto_receber), 0);
        bus.sensor_caixa = 1'b1;
        @(negedge clk);
        check("pronto_com_caixa", int'(bus.pronto_receber), 1);

        // Single bottle.
        garrafa();
        check("pronto_baixo_deposito", int'(bus.pronto_receber), 0);
        repeat (TD) @(negedge clk);
        check("garrafas_um", int'(bus.garrafas_na_caixa), 1);
        check("pronto_volta", int'(bus.pronto_receber), 1);

        // Complete the case; swap request holds while the case stays.
        garrafa();
        garrafa();
        wait_pedido();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pedido_mantido", int'(bus.pedido_troca), 1);
        end
        bus.sensor_caixa = 1'b0;
        @(negedge clk);
        check("pedido_limpo", int'(bus.pedido_troca), 0);
        check("alarme_troca_curta", int'(bus.alarme_troca), 0);
        check("total_um", int'(bus.total_caixas), 1);
        check("erro_ainda_zero", int'(bus.erro_sequencia), 0);
        bus.sensor_caixa = 1'b1;

        // Bottle during DEPOSITA is ignored and flagged.
        garrafa();
        @(negedge clk);
        bus.garrafa_valida = 1'b1;
        @(negedge clk);
        bus.garrafa_valida = 1'b0;
        check("erro_garrafa_fora", int'(bus.erro_sequencia), 1);
        check("garrafas_sem_extra", int'(bus.garrafas_na_caixa), 1);
        check("pronto_apos_extra", int'(bus.pronto_receber), 1);

        // Case removed while receiving with two bottles: count discarded.
        garrafa();
        wait_pronto();
        bus.sensor_caixa = 1'b0;
        m_count = 0;
        @(negedge clk);
        check("garrafas_apos_remocao", int'(bus.garrafas_na_caixa), 0);
        check("espera_apos_remocao", int'(bus.pronto_receber), 0);
        check("erro_remocao", int'(bus.erro_sequencia), 1);
        bus.sensor_caixa = 1'b1;
        @(negedge clk);
        check("pronto_nova_caixa", int'(bus.pronto_receber), 1);

        // One hundred randomized cases: total saturates, pulses continue.
        for (int c = 0; c < 100; c++) begin
            for (int b = 0; b < G; b++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                garrafa();
            end
            troca($urandom_range(0, 3));
        end
        @(negedge clk);
        check("total_saturado", int'(bus.total_caixas), MAXC);
        check("total_modelo", int'(bus.total_caixas), m_total);

        // Swap timeout boundary: quiet after 8 cycles, alarm in the 9th.
        garrafa();
        garrafa();
        garrafa();
        wait_pedido();
        repeat (TO - 1) @(negedge clk);
        check("alarme_antes_limite", int'(bus.alarme_troca), 0);
        @(negedge clk);
        check("alarme_no_limite", int'(bus.alarme_troca), EXP_ALARME);
        check("pedido_durante_alarme", int'(bus.pedido_troca), 1);
        repeat (3) @(negedge clk);
        check("pedido_ainda", int'(bus.pedido_troca), 1);
        bus.sensor_caixa = 1'b0;
        @(negedge clk);
        check("pedido_fim_alarme", int'(bus.pedido_troca), 0);
        check("alarme_pegajoso", int'(bus.alarme_troca), EXP_ALARME);
        check("erro_pegajoso", int'(bus.erro_sequencia), 1);
        bus.sensor_caixa = 1'b1;

        // Reset in the middle of a deposit discards everything.
        garrafa();
        reset = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_total = 0;
        @(negedge clk);
        check_idle("reset_meio");
        reset = 1'b1;
        @(negedge clk);
        check("pronto_pos_reset", int'(bus.pronto_receber), 1);

        repeat (2) @(negedge clk);
        check("fila_vazia", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
